// File: rtl/mult_seq_ctrl.sv
// Iterative shift-add unsigned multiplier with its own sequencing FSM.
// One partial-product iteration per clk edge; product is valid on a single-cycle done pulse.
module mult_seq_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             cancel,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] product_hi,
   output logic [WIDTH-1:0] product_lo
);

   // state | meaning
   // IDLE  | waiting for start; product registers hold the last result
   // RUN   | one shift-add iteration per edge, WIDTH iterations total
   // DONE  | product valid, done high for this single cycle

   localparam int CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] mq;
   logic [CNT_W-1:0] count;
   logic [WIDTH:0]   sum;
   logic             accept;
   logic             last;

   assign accept = (state == IDLE) && start && !cancel;
   assign last   = (count == CNT_W'(WIDTH - 1));

   // The carry out of the add lands in acc's MSB after the shift, so nothing overflows.
   assign sum = {1'b0, acc} + (mq[0] ? {1'b0, mcand} : {(WIDTH + 1){1'b0}});

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (cancel) begin
               state_nxt = IDLE;
            end else if (last) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_comb begin
      busy  = (state != IDLE);
      stall = accept || (state == RUN);
      done  = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mcand <= '0;
         acc   <= '0;
         mq    <= '0;
         count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  mcand <= op_a;
                  acc   <= '0;
                  mq    <= op_b;
                  count <= '0;
               end
            end
            RUN: begin
               if (!cancel) begin
                  {acc, mq} <= {sum, mq[WIDTH-1:1]};
                  if (!last) begin
                     count <= count + CNT_W'(1);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign product_hi = acc;
   assign product_lo = mq;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl: one task per scenario, hand-computed expected values.
module tb_mult_seq_ctrl;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic             cancel;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             busy;
   logic             stall;
   logic             done;
   logic [WIDTH-1:0] product_hi;
   logic [WIDTH-1:0] product_lo;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   mult_seq_ctrl #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .cancel     (cancel),
      .op_a       (op_a),
      .op_b       (op_b),
      .busy       (busy),
      .stall      (stall),
      .done       (done),
      .product_hi (product_hi),
      .product_lo (product_lo)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one accepted request; returns 1 ns after the accepting edge.
   task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      op_a  = a;
      op_b  = b;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Tick until done is seen or the limit expires; cyc is edges since the accepting edge.
   task automatic wait_done(input int limit, output int cyc, output logic seen);
      seen = 1'b0;
      cyc  = 0;
      for (int i = 1; i <= limit; i++) begin
         tick();
         if (done === 1'b1) begin
            cyc  = i;
            seen = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b1;
      cancel = 1'b0;
      op_a = 32'd9;
      op_b = 32'd9;
      repeat (3) tick();
      tests++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         fails++;
         $display("FAIL reset_ctrl: busy=%b done=%b, required busy=0 done=0", busy, done);
      end
      tests++;
      if (product_hi !== '0 || product_lo !== '0) begin
         fails++;
         $display("FAIL reset_product: %h_%h, required 0_0", product_hi, product_lo);
      end
      start = 1'b0;
      reset = 1'b0;
      tick();
      tests++;
      if (busy !== 1'b0 || stall !== 1'b0) begin
         fails++;
         $display("FAIL reset_idle: busy=%b stall=%b, required 0 0", busy, stall);
      end
   endtask

   task automatic test_basic();
      int   done_at;
      logic stall_bad;
      logic early_done;
      op_a  = 32'd3;
      op_b  = 32'd5;
      start = 1'b1;
      #1;
      tests++;
      if (stall !== 1'b1) begin
         fails++;
         $display("FAIL basic_stall_start: stall=%b, required 1", stall);
      end
      tick();
      start = 1'b0;
      tests++;
      if (busy !== 1'b1) begin
         fails++;
         $display("FAIL basic_busy: busy=%b, required 1", busy);
      end
      done_at    = 0;
      stall_bad  = 1'b0;
      early_done = 1'b0;
      for (int n = 1; n <= WIDTH; n++) begin
         if (n < WIDTH && stall !== 1'b1) stall_bad = 1'b1;
         tick();
         if (n < WIDTH && done !== 1'b0) early_done = 1'b1;
         if (done === 1'b1 && done_at == 0) done_at = n;
      end
      tests++;
      if (done_at != WIDTH || early_done) begin
         fails++;
         $display("FAIL basic_done_latency: done at %0d (early=%b), required %0d", done_at, early_done, WIDTH);
      end
      tests++;
      if (stall_bad || stall !== 1'b0) begin
         fails++;
         $display("FAIL basic_stall_run: bad=%b stall_in_done=%b, required high in RUN, low in DONE", stall_bad, stall);
      end
      tests++;
      if (product_hi !== 32'd0 || product_lo !== 32'd15) begin
         fails++;
         $display("FAIL basic_product: %h_%h, required 00000000_0000000f", product_hi, product_lo);
      end
      tick();
      tests++;
      if (busy !== 1'b0 || done !== 1'b0 || product_lo !== 32'd15) begin
         fails++;
         $display("FAIL basic_after: busy=%b done=%b lo=%h, required 0 0 0000000f", busy, done, product_lo);
      end
   endtask

   task automatic test_max_operands();
      int   cyc;
      logic seen;
      start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(WIDTH + 8, cyc, seen);
      tests++;
      if (!seen || product_hi !== 32'hFFFF_FFFE || product_lo !== 32'h0000_0001) begin
         fails++;
         $display("FAIL max_ffff: seen=%b %h_%h, required fffffffe_00000001", seen, product_hi, product_lo);
      end
      tick();
      start_op(32'h8000_0000, 32'd2);
      wait_done(WIDTH + 8, cyc, seen);
      tests++;
      if (!seen || product_hi !== 32'd1 || product_lo !== 32'd0) begin
         fails++;
         $display("FAIL max_msb: seen=%b %h_%h, required 00000001_00000000", seen, product_hi, product_lo);
      end
      tick();
   endtask

   task automatic test_ignored_start();
      int               dones;
      int               first_at;
      logic [WIDTH-1:0] first_lo;
      start_op(32'd7, 32'd9);
      dones    = 0;
      first_at = 0;
      first_lo = '0;
      for (int i = 1; i <= WIDTH + 40; i++) begin
         if (i == 10) begin
            start = 1'b1;
            op_a  = 32'd100;
            op_b  = 32'd100;
         end else if (i == 11) begin
            start = 1'b0;
            op_a  = 32'd55;
            op_b  = 32'd77;
         end
         tick();
         if (done === 1'b1) begin
            dones++;
            if (first_at == 0) begin
               first_at = i;
               first_lo = product_lo;
            end
         end
      end
      tests++;
      if (dones != 1 || first_at != WIDTH) begin
         fails++;
         $display("FAIL ignore_done_count: dones=%0d first_at=%0d, required 1 at %0d", dones, first_at, WIDTH);
      end
      tests++;
      if (first_lo !== 32'd63) begin
         fails++;
         $display("FAIL ignore_product: lo=%0d, required 63", first_lo);
      end
   endtask

   task automatic test_back_to_back();
      int               d1;
      int               d2;
      logic [WIDTH-1:0] p1;
      logic [WIDTH-1:0] p1_hi;
      logic [WIDTH-1:0] p2;
      logic [WIDTH-1:0] gap_lo;
      logic             gap_busy;
      logic             gap_stall;
      op_a  = 32'd6;
      op_b  = 32'd7;
      start = 1'b1;
      tick();
      op_a = 32'd0;
      op_b = 32'hDEAD_BEEF;
      d1 = 0;
      d2 = 0;
      p1 = '1;
      p1_hi = '1;
      p2 = '1;
      gap_lo = '1;
      gap_busy = 1'b1;
      gap_stall = 1'b0;
      for (int i = 1; i <= 2 * WIDTH + 10; i++) begin
         tick();
         if (i == WIDTH + 1) begin
            gap_lo    = product_lo;
            gap_busy  = busy;
            gap_stall = stall;
         end
         if (done === 1'b1) begin
            if (d1 == 0) begin
               d1 = i;
               p1 = product_lo;
               p1_hi = product_hi;
            end else begin
               d2 = i;
               p2 = product_lo;
               break;
            end
         end
      end
      start = 1'b0;
      tests++;
      if (d1 != WIDTH || d2 - d1 != WIDTH + 2) begin
         fails++;
         $display("FAIL b2b_spacing: d1=%0d d2=%0d, required %0d and %0d", d1, d2, WIDTH, 2 * WIDTH + 2);
      end
      tests++;
      if (p1 !== 32'd42 || p1_hi !== 32'd0 || p2 !== 32'd0) begin
         fails++;
         $display("FAIL b2b_products: %0d (hi %0d) then %0d, required 42 (hi 0) then 0", p1, p1_hi, p2);
      end
      tests++;
      if (gap_lo !== 32'd42 || gap_busy !== 1'b0 || gap_stall !== 1'b1) begin
         fails++;
         $display("FAIL b2b_gap: lo=%0d busy=%b stall=%b, required 42 0 1", gap_lo, gap_busy, gap_stall);
      end
      tick();
      tests++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL b2b_idle: busy=%b, required 0", busy);
      end
   endtask

   task automatic test_cancel_reset();
      int   cyc;
      logic seen;
      start_op(32'd11, 32'd13);
      repeat (4) tick();
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      tests++;
      if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
         fails++;
         $display("FAIL cancel_idle: busy=%b done=%b stall=%b, required 0 0 0", busy, done, stall);
      end
      wait_done(40, cyc, seen);
      tests++;
      if (seen !== 1'b0) begin
         fails++;
         $display("FAIL cancel_no_done: done seen after %0d cycles, required none", cyc);
      end
      start_op(32'd11, 32'd13);
      repeat (19) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tests++;
      if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0 || product_hi !== '0 || product_lo !== '0) begin
         fails++;
         $display("FAIL reset_midrun: busy=%b done=%b stall=%b %h_%h, required all 0",
                  busy, done, stall, product_hi, product_lo);
      end
      wait_done(40, cyc, seen);
      tests++;
      if (seen !== 1'b0) begin
         fails++;
         $display("FAIL reset_no_done: done seen after %0d cycles, required none", cyc);
      end
      start_op(32'd11, 32'd13);
      wait_done(WIDTH + 8, cyc, seen);
      tests++;
      if (!seen || cyc != WIDTH || product_hi !== '0 || product_lo !== 32'd143) begin
         fails++;
         $display("FAIL recover_product: seen=%b cyc=%0d %0d_%0d, required 1 %0d 0_143",
                  seen, cyc, product_hi, product_lo, WIDTH);
      end
      tick();
   endtask

   task automatic test_cancel_collision();
      int   cyc;
      logic seen;
      op_a   = 32'd5;
      op_b   = 32'd5;
      start  = 1'b1;
      cancel = 1'b1;
      #1;
      tests++;
      if (stall !== 1'b0) begin
         fails++;
         $display("FAIL collide_stall: stall=%b, required 0", stall);
      end
      tick();
      start  = 1'b0;
      cancel = 1'b0;
      tests++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL collide_busy: busy=%b, required 0", busy);
      end
      start_op(32'd2, 32'd3);
      wait_done(WIDTH + 8, cyc, seen);
      cancel = 1'b1;
      #1;
      tests++;
      if (!seen || done !== 1'b1 || product_lo !== 32'd6) begin
         fails++;
         $display("FAIL done_cancel_pulse: seen=%b done=%b lo=%0d, required 1 1 6", seen, done, product_lo);
      end
      tick();
      cancel = 1'b0;
      tests++;
      if (busy !== 1'b0 || done !== 1'b0 || product_lo !== 32'd6) begin
         fails++;
         $display("FAIL done_cancel_idle: busy=%b done=%b lo=%0d, required 0 0 6", busy, done, product_lo);
      end
   endtask

   initial begin
      reset  = 1'b1;
      start  = 1'b0;
      cancel = 1'b0;
      op_a   = '0;
      op_b   = '0;
      test_reset();
      test_basic();
      test_max_operands();
      test_ignored_start();
      test_back_to_back();
      test_cancel_reset();
      test_cancel_collision();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
- Iterative shift-add multiplier with its own sequencing FSM, for the calc datapath.
- Runs on the single module clock `clk`, replacing the separate fast multiplier clock.
- Accepts a multiply request from decode, stalls the PC/fetch path while iterating, then presents a 2*WIDTH product with a one-cycle done pulse.
- Supports cancel (pipeline flush) and synchronous reset at any point.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH; must be >= 2.
- CNT_W, $clog2(WIDTH)+1, iteration-counter width (derived, not overridden).

Ports:
- clk  input  1  module clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high; returns block to IDLE.
- start  input  1  multiply request; sampled only in IDLE.
- cancel  input  1  flush: abort an in-flight multiply; no done is produced.
- op_a  input  WIDTH  multiplicand, unsigned; captured on accepting edge.
- op_b  input  WIDTH  multiplier, unsigned; captured on accepting edge.
- busy  output  1  high whenever state != IDLE.
- stall  output  1  hold PC/fetch: (state==IDLE & start & !cancel) | (state==RUN).
- done  output  1  one-cycle pulse, product valid.
- product_hi  output  WIDTH  upper half of op_a*op_b.
- product_lo  output  WIDTH  lower half of op_a*op_b.

Behaviour:
- Reset:
  - state=IDLE, busy=0, done=0, count=0, product_hi=product_lo=0.
  - Internal multiplicand register cleared.
  - Reset overrides start and cancel.
- State IDLE:
  - If start & !cancel at edge k: latch mcand=op_a, {acc,mq}={0,op_b}, count=0, go to RUN.
  - Otherwise stay in IDLE.
- State RUN, one iteration per edge:
  - sum[WIDTH:0] = acc + (mq[0] ? mcand : 0), keeping the carry bit.
  - Then {acc,mq} = {sum,mq} >> 1, so the carry enters acc MSB.
  - count increments each iteration.
  - The iteration with count==WIDTH-1 (edge k+WIDTH) also moves state to DONE.
  - acc/mq are the product_hi/product_lo registers: product_hi=acc, product_lo=mq.
- State DONE:
  - done=1 for exactly this one cycle, WIDTH cycles after the accepting edge.
  - Next edge goes to IDLE unconditionally; a start seen in DONE is ignored.
  - Earliest next accept is at edge k+WIDTH+2.
- Product hold: product_hi/lo hold their value in DONE and in IDLE until the next accepted start.
- Operand changes: op_a/op_b changing during RUN have no effect.
- start while busy: ignored, with no queuing.
- cancel:
  - In RUN: next edge goes to IDLE; done is never asserted; product registers keep partial contents, which are undefined for consumers.
  - In DONE: done still pulses that cycle, and the state returns to IDLE as normal.
  - In IDLE together with start: the request is rejected, and stall stays 0.
- Simultaneous reset+cancel, or reset+start: reset wins.
- Reset mid-RUN: IDLE and cleared outputs after that edge; no done.
- Width and arithmetic rules:
  - Unsigned only.
  - No overflow is possible: the WIDTH+1-bit sum is always absorbed by the shift.
  - Counter never wraps: max value WIDTH-1 in RUN, then cleared on the next accept.
- stall: combinational from start/cancel in IDLE; registered-state-only otherwise. It is low in DONE so the consumer can write back the product on the done cycle.

Test Plan:
- Basic multiply:
  - Stimulus: reset 3 cycles, then start=1 for one cycle with op_a=3, op_b=5.
  - Required: busy rises next cycle; done pulses exactly 32 cycles after the accepting edge; product_hi=0, product_lo=15; stall high from the start cycle through the last RUN cycle.
- Max operands:
  - Stimulus: op_a=op_b=0xFFFFFFFF.
  - Required: product_hi=0xFFFFFFFE, product_lo=0x00000001.
  - Also op_a=0x80000000, op_b=2 -> product_hi=1, product_lo=0.
- Ignored start while busy:
  - Stimulus: accept 7*9; at iteration 10 pulse start with op_a=100, op_b=100 and change op_a/op_b.
  - Required: a single done, product_lo=63; no second done within the next 40 cycles.
- Back-to-back:
  - Stimulus: hold start=1 continuously with 6*7 then 0*0xDEADBEEF.
  - Required: dones 34 cycles apart (WIDTH+2); products 42 then 0.
  - Product held at 42 during the IDLE cycle between them.
- Cancel and reset mid-op:
  - Stimulus: accept 11*13; cancel at iteration 5.
  - Required: IDLE next cycle, busy=0, no done.
  - Then accept 11*13 again and assert reset at iteration 20: all outputs 0 next cycle, no done.
  - A subsequent 11*13 yields 143.
- Cancel collisions:
  - Stimulus: start with cancel in IDLE.
  - Required: not accepted, stall=0, busy stays 0.
  - Stimulus: cancel in the DONE cycle.
  - Required: done still 1 for that cycle, then IDLE.
